// File: rtl/ex_muldiv.sv
// ex_muldiv: EX-stage multi-cycle MULT/MULTU/DIV/DIVU unit producing HI/LO and a pipeline stall.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiply; divide always iterates DIV_CYCLES cycles.
module ex_muldiv #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ex_start,
    input  logic [1:0]  ex_op,
    input  logic [31:0] ex_A,
    input  logic [31:0] ex_B,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);
    localparam int CW = $clog2(DIV_CYCLES);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
    state_t      r_state;
    logic [CW-1:0] r_count;
    logic        r_div, r_neg, r_neg_a;
    logic [31:0] r_a, r_b, r_hi, r_lo;
    logic [63:0] r_acc;
    logic        w_sgn, w_accept, w_last;
    logic [31:0] w_a_mag, w_b_mag, w_q, w_r, w_hi_nxt, w_lo_nxt;
    logic [32:0] w_sub;
    logic [63:0] w_div_nxt, w_acc_nxt, w_prod;
    assign w_sgn    = ~ex_op[0];
    assign w_a_mag  = (w_sgn && ex_A[31]) ? -ex_A : ex_A;
    assign w_b_mag  = (w_sgn && ex_B[31]) ? -ex_B : ex_B;
    assign w_accept = (r_state == S_IDLE) && ex_start && !flush;
    assign busy     = w_accept || (r_state == S_CALC);
    assign done     = r_state == S_DONE;
    assign hi_o     = r_hi;
    assign lo_o     = r_lo;
    // Restoring step: r_acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}
    assign w_sub     = r_acc[63:31] - {1'b0, r_b};
    assign w_div_nxt = w_sub[32] ? {r_acc[62:31], r_acc[30:0], 1'b0} : {w_sub[31:0], r_acc[30:0], 1'b1};
`ifdef MULDIV_FAST_MUL_EN
    assign w_acc_nxt = r_div ? w_div_nxt : {32'b0, r_a} * {32'b0, r_b};
    assign w_last    = r_div ? (r_count == CW'(DIV_CYCLES - 1)) : 1'b1;
`else
    logic [32:0] w_add;
    assign w_add     = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_a} : 33'd0);
    assign w_acc_nxt = r_div ? w_div_nxt : {w_add, r_acc[31:1]};
    assign w_last    = r_count == CW'(DIV_CYCLES - 1);
`endif
    assign w_prod   = r_neg ? -w_acc_nxt : w_acc_nxt;
    assign w_q      = r_neg ? -w_acc_nxt[31:0] : w_acc_nxt[31:0];
    assign w_r      = r_neg_a ? -w_acc_nxt[63:32] : w_acc_nxt[63:32];
    // Divide by zero returns all-ones quotient and the raw dividend, rebuilt from its magnitude
    assign w_hi_nxt = !r_div ? w_prod[63:32] : (r_b == 32'd0) ? (r_neg_a ? -r_a : r_a) : w_r;
    assign w_lo_nxt = !r_div ? w_prod[31:0] : (r_b == 32'd0) ? 32'hFFFF_FFFF : w_q;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_div   <= 1'b0;
            r_neg   <= 1'b0;
            r_neg_a <= 1'b0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_acc   <= 64'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_state <= S_CALC;
                    r_count <= '0;
                    r_div   <= ex_op[1];
                    r_neg   <= w_sgn & (ex_A[31] ^ ex_B[31]);
                    r_neg_a <= w_sgn & ex_A[31];
                    r_a     <= w_a_mag;
                    r_b     <= w_b_mag;
                    r_acc   <= {32'd0, ex_op[1] ? w_a_mag : w_b_mag};
                end
                S_CALC: if (flush) begin
                    r_state <= S_IDLE;
                end else begin
                    r_acc   <= w_acc_nxt;
                    r_count <= r_count + 1'b1;
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_hi    <= w_hi_nxt;
                        r_lo    <= w_lo_nxt;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
